zero_pattern_source: RTL and testbench
======================================

ZERO_PATTERN_SOURCE -- requirements
Module: zero_pattern_source

Interface
REQ-001 Parameter: WIDTH, default 64, data word width; power of two, 2..64.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request a new pattern sequence; sampled only in IDLE.
REQ-005 Port: pattern_sel  input  2  sequence select: 0 all-zero, 1 all-ones, 2 walking-zero, 3 walking-one.
REQ-006 Port: out_data  output  WIDTH  generated word, fed to a zero detector under test.
REQ-007 Port: out_valid  output  1  out_data and exp_zero are valid.
REQ-008 Port: out_ready  input  1  consumer accepts the word this cycle.
REQ-009 Port: exp_zero  output  1  expected detector result: 1 iff out_data is all zeros.
REQ-010 Port: busy  output  1  sequence in progress (state RUN).
REQ-011 Port: done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-012 FSM states: IDLE, RUN, DONE.
REQ-013 IDLE -> RUN on the edge where start=1; pattern_sel is latched on that edge; index is cleared to 0.
REQ-014 Sequence length: 1 word for modes 0/1, WIDTH words for modes 2/3.
REQ-015 Word k, mode 0: all zeros; mode 1: all ones; mode 2: all ones with bit k cleared; mode 3: all zeros with bit k set.
REQ-016 out_valid=1 throughout RUN; the first word appears the cycle after start is sampled (latency 1).
REQ-017 Transfer occurs on an edge where out_valid=1 and out_ready=1; index increments by 1 per transfer.
REQ-018 While out_valid=1 and out_ready=0, out_data and exp_zero hold stable.
REQ-019 A transfer of the last word (index=length-1) moves RUN -> DONE; the index does not wrap into a new word.
REQ-020 DONE lasts exactly one cycle with done=1, then the FSM returns to IDLE unconditionally.
REQ-021 start is ignored in RUN and DONE; a new sequence requires start in IDLE.
REQ-022 pattern_sel changes after latching have no effect until the next start.
REQ-023 exp_zero is combinational from out_data (reduction NOR) and is 1 only in mode 0 while valid.
REQ-024 In IDLE and DONE: out_valid=0, out_data=0, exp_zero=0.
REQ-025 Index counter width: clog2(WIDTH)+1 bits, so the comparison with length is free of overflow.

Reset
REQ-026 rst=1 at a clock edge forces IDLE, index=0, latched select=0, out_valid=0, busy=0, done=0, out_data=0.
REQ-027 rst takes priority over start and any handshake; asserted mid-RUN, it aborts the sequence with no done pulse.
REQ-028 The first start is honoured on the first edge after rst deasserts.

Structure
REQ-029 The shared package holds: the state enum (IDLE/RUN/DONE), the pattern_sel codes (PAT_ZERO, PAT_ONES, PAT_WALK0, PAT_WALK1), and the DEFAULT_WIDTH=64 constant.
REQ-030 One sub-module, pattern_word_gen, is purely combinational and maps (latched select, index) to the word.
REQ-031 The top contains the FSM, the index counter and the handshake; all state is on clk.

Verification
REQ-032 rst, then start with pattern_sel=0 and out_ready=1 -> one word 64'h0, exp_zero=1, then done pulse 1 cycle later.
REQ-033 start with pattern_sel=1 and out_ready=1 -> one word 64'hFFFF_FFFF_FFFF_FFFF, exp_zero=0, then done.
REQ-034 start with pattern_sel=2 and out_ready=1 -> 64 words; word 25 = 64'hFFFF_FFFF_FDFF_FFFF; done after word 63; exp_zero=0 throughout.
REQ-035 start with pattern_sel=3 and out_ready toggled 1/0 every cycle -> words hold while out_ready=0; the sequence 1<<k is complete, with no duplicates or skips.
REQ-036 Mode 2 running, rst at word 10 -> next cycle out_valid=0, with no done; a subsequent start restarts at word 0.
REQ-037 start held high through RUN and DONE -> a single sequence only; the next sequence begins only after the FSM returns to IDLE.

Source files
------------

// File: rtl/zero_pattern_source_pkg.sv
// Shared types and constants for the zero-detector pattern source.
// Holds the FSM state type, the pattern select codes and the default word width.
package zero_pattern_source_pkg;

    localparam int DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] PAT_ZERO  = 2'd0;
    localparam logic [1:0] PAT_ONES  = 2'd1;
    localparam logic [1:0] PAT_WALK0 = 2'd2;
    localparam logic [1:0] PAT_WALK1 = 2'd3;

    // The walking patterns emit one word per bit position; the others emit one word.
    function automatic logic is_walking(input logic [1:0] sel);
        return (sel == PAT_WALK0) || (sel == PAT_WALK1);
    endfunction

endpackage

// File: rtl/zero_pattern_source_pattern_word_gen.sv
// Combinational mapping from (pattern select, word index) to the generated word.
module pattern_word_gen
    import zero_pattern_source_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH) + 1
) (
    input  logic [1:0]       sel_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] onehot;

    assign onehot = {{(WIDTH-1){1'b0}}, 1'b1} << idx_i;

    always_comb begin
        word_o = '0;
        case (sel_i)
            PAT_ZERO:  word_o = '0;
            PAT_ONES:  word_o = '1;
            PAT_WALK0: word_o = ~onehot;
            default:   word_o = onehot;
        endcase
    end

endmodule

// File: rtl/zero_pattern_source.sv
// Pattern source for exercising a zero detector: emits a latched word sequence over a
// valid/ready handshake together with the expected detector result.
module zero_pattern_source
    import zero_pattern_source_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       pattern_sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             exp_zero,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] WALK_LAST = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_idx;
    logic [WIDTH-1:0] word;

    assign last_idx = is_walking(sel_q) ? WALK_LAST : '0;

    pattern_word_gen #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_word_gen (
        .sel_i  (sel_q),
        .idx_i  (idx_q),
        .word_o (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= PAT_ZERO;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
        end
    end

    // The index stops on the last word; leaving RUN is what ends the sequence.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sel_d   = pattern_sel;
                    idx_d   = '0;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    if (idx_q == last_idx) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_data = out_valid ? word : '0;
    assign exp_zero = out_valid & ~(|out_data);

endmodule

// File: tb/tb_zero_pattern_source.sv
// Randomized and directed bench for zero_pattern_source against a queue-based model.
module tb_zero_pattern_source;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       patternSel;
    logic [WIDTH-1:0] outData;
    logic             outValid;
    logic             outReady;
    logic             expZero;
    logic             busy;
    logic             done;

    int checks = 0;
    int passes = 0;
    bit checkEn = 0;

    logic [63:0] modelQ[$];
    bit          modelDone = 0;
    logic [63:0] accepted[$];
    int          zeroFlags;
    bit          gotDone;

    zero_pattern_source #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pattern_sel (patternSel),
        .out_data    (outData),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .exp_zero    (expZero),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic buildSequence(input logic [1:0] sel);
        case (sel)
            2'd0: modelQ.push_back(64'h0);
            2'd1: modelQ.push_back('1);
            2'd2: for (int k = 0; k < WIDTH; k++) modelQ.push_back(~(64'h1 << k));
            default: for (int k = 0; k < WIDTH; k++) modelQ.push_back(64'h1 << k);
        endcase
    endtask

    // Model: a queue of words still owed to the consumer, plus a pending done pulse.
    always @(posedge clk) begin
        if (rst) begin
            modelQ.delete();
            modelDone = 0;
        end else if (modelDone) begin
            modelDone = 0;
        end else if (modelQ.size() != 0) begin
            if (outReady) begin
                void'(modelQ.pop_front());
                if (modelQ.size() == 0) modelDone = 1;
            end
        end else if (start) begin
            buildSequence(patternSel);
        end
    end

    always @(negedge clk) begin : compare
        bit          expValid;
        logic [63:0] expWord;
        if (checkEn) begin
            expValid = (modelQ.size() != 0);
            expWord  = expValid ? modelQ[0] : 64'h0;
            checkOutput("out_valid", 64'(outValid), 64'(expValid));
            checkOutput("out_data", outData, expWord);
            checkOutput("exp_zero", 64'(expZero), 64'(expValid && expWord == 64'h0));
            checkOutput("busy", 64'(busy), 64'(expValid));
            checkOutput("done", 64'(done), 64'(modelDone));
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one sequence from IDLE; readyMode 0 = always ready, 1 = toggling, 2 = random.
    task automatic applyStimulus(input logic [1:0] sel, input int readyMode);
        accepted.delete();
        zeroFlags  = 0;
        gotDone    = 0;
        start      = 1'b1;
        patternSel = sel;
        stepCycle();
        start = 1'b0;
        for (int c = 0; c < 400 && !gotDone; c++) begin
            case (readyMode)
                0:       outReady = 1'b1;
                1:       outReady = (c % 2 == 0);
                default: outReady = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (done) begin
                gotDone = 1;
            end else if (outValid) begin
                if (expZero) zeroFlags++;
                if (outReady) accepted.push_back(outData);
            end
            stepCycle();
        end
        outReady = 1'b0;
        checkOutput("seq_done_seen", 64'(gotDone), 64'h1);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        patternSel = 2'd0;
        outReady   = 1'b0;
        stepCycle();
        checkEn = 1;
        stepCycle();
        @(negedge clk);
        checkOutput("rst_valid", 64'(outValid), 64'h0);
        checkOutput("rst_data", outData, 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_done", 64'(done), 64'h0);
        stepCycle();

        // Mode 0 directly after reset release.
        rst        = 1'b0;
        start      = 1'b1;
        patternSel = 2'd0;
        outReady   = 1'b1;
        stepCycle();
        start = 1'b0;
        @(negedge clk);
        checkOutput("m0_valid", 64'(outValid), 64'h1);
        checkOutput("m0_data", outData, 64'h0);
        checkOutput("m0_expzero", 64'(expZero), 64'h1);
        stepCycle();
        @(negedge clk);
        checkOutput("m0_done", 64'(done), 64'h1);
        stepCycle();
        @(negedge clk);
        checkOutput("m0_done_clear", 64'(done), 64'h0);
        stepCycle();

        applyStimulus(2'd1, 0);
        checkOutput("m1_len", 64'(accepted.size()), 64'd1);
        if (accepted.size() == 1) checkOutput("m1_word", accepted[0], 64'hFFFF_FFFF_FFFF_FFFF);

        applyStimulus(2'd2, 0);
        checkOutput("m2_len", 64'(accepted.size()), 64'd64);
        checkOutput("m2_zero_flags", 64'(zeroFlags), 64'd0);
        if (accepted.size() == 64) begin
            checkOutput("m2_word25", accepted[25], 64'hFFFF_FFFF_FDFF_FFFF);
            checkOutput("m2_word63", accepted[63], 64'h7FFF_FFFF_FFFF_FFFF);
        end

        applyStimulus(2'd3, 1);
        checkOutput("m3_len", 64'(accepted.size()), 64'd64);
        for (int k = 0; k < accepted.size() && k < 64; k++)
            checkOutput($sformatf("m3_word%0d", k), accepted[k], 64'h1 << k);

        // Reset while mode 2 shows word 10.
        start      = 1'b1;
        patternSel = 2'd2;
        outReady   = 1'b1;
        stepCycle();
        start = 1'b0;
        repeat (10) stepCycle();
        @(negedge clk);
        checkOutput("abort_word10", outData, 64'hFFFF_FFFF_FFFF_FBFF);
        rst = 1'b1;
        stepCycle();
        rst      = 1'b0;
        outReady = 1'b0;
        @(negedge clk);
        checkOutput("abort_valid", 64'(outValid), 64'h0);
        checkOutput("abort_done", 64'(done), 64'h0);
        stepCycle();
        @(negedge clk);
        checkOutput("abort_no_done", 64'(done), 64'h0);
        stepCycle();
        applyStimulus(2'd2, 2);
        checkOutput("restart_len", 64'(accepted.size()), 64'd64);
        if (accepted.size() != 0) checkOutput("restart_word0", accepted[0], 64'hFFFF_FFFF_FFFF_FFFE);

        // start held high through RUN and DONE; select changed after latching.
        start      = 1'b1;
        patternSel = 2'd1;
        outReady   = 1'b1;
        stepCycle();
        patternSel = 2'd0;
        @(negedge clk);
        checkOutput("held_word", outData, 64'hFFFF_FFFF_FFFF_FFFF);
        stepCycle();
        @(negedge clk);
        checkOutput("held_done", 64'(done), 64'h1);
        checkOutput("held_done_valid", 64'(outValid), 64'h0);
        stepCycle();
        @(negedge clk);
        checkOutput("held_idle_valid", 64'(outValid), 64'h0);
        checkOutput("held_idle_busy", 64'(busy), 64'h0);
        stepCycle();
        start = 1'b0;
        @(negedge clk);
        checkOutput("held_second_valid", 64'(outValid), 64'h1);
        checkOutput("held_second_expzero", 64'(expZero), 64'h1);
        repeat (3) stepCycle();

        // Random traffic: start noise, select changes, backpressure and occasional reset.
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            start      = ($urandom_range(0, 3) == 0);
            patternSel = 2'($urandom_range(0, 3));
            outReady   = 1'($urandom_range(0, 1));
            stepCycle();
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) stepCycle();

        checkEn = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
